// File: rtl/riscv_lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package riscv_lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    DONE = 2'b11
  } lsu_state_t;

  // RISC-V load/store funct3 encodings; bit 2 selects zero-extension on loads
  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_D  = 3'b011;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;
  localparam logic [2:0] LS_WU = 3'b110;

  localparam logic [1:0] FC_NONE       = 2'b00;
  localparam logic [1:0] FC_MISALIGNED = 2'b01;
  localparam logic [1:0] FC_ILLEGAL    = 2'b10;
  localparam logic [1:0] FC_TIMEOUT    = 2'b11;

  // Natural alignment check: the access size is encoded in funct3[1:0]
  function automatic logic isMisaligned(input logic [2:0] funct3, input logic [2:0] lowAddr);
    logic bad;
    case (funct3[1:0])
      2'd1:    bad = lowAddr[0];
      2'd2:    bad = |lowAddr[1:0];
      2'd3:    bad = |lowAddr[2:0];
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/riscv_lsu_lane_align.sv
// Byte-lane steering: store byte enables and lane replication, load shift and extension.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module lsu_lane_align
  import riscv_lsu_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int NB = XLEN / 8,
  localparam int OFF_W = $clog2(XLEN / 8)
) (
  input  logic [2:0]       funct3,
  input  logic [OFF_W-1:0] off,
  input  logic [XLEN-1:0]  stData,
  input  logic [XLEN-1:0]  ldData,
  output logic [NB-1:0]    byteEn,
  output logic [XLEN-1:0]  stLanes,
  output logic [XLEN-1:0]  ldResult
);

  logic [NB-1:0]   sizeMask;
  logic [XLEN-1:0] ldShifted;

  // One enable bit per byte covered by the access size, before lane offset
  always_comb begin
    sizeMask = '0;
    for (int i = 0; i < NB; i++) begin
      sizeMask[i] = (i < (1 << funct3[1:0]));
    end
  end

  assign byteEn = sizeMask << off;

  // Replicate the low byte/half/word so whichever lanes are enabled see the data
  always_comb begin
    stLanes = stData;
    case (funct3[1:0])
      2'd0:    stLanes = {NB{stData[7:0]}};
      2'd1:    stLanes = {(NB / 2){stData[15:0]}};
      2'd2:    stLanes = {(XLEN / 32){stData[31:0]}};
      default: stLanes = stData;
    endcase
  end

  assign ldShifted = ldData >> {off, 3'b000};

  // Truncate the shifted word to the access size, then sign- or zero-extend
  always_comb begin
    ldResult = ldShifted;
    case (funct3)
      LS_B:    ldResult = XLEN'($signed(ldShifted[7:0]));
      LS_H:    ldResult = XLEN'($signed(ldShifted[15:0]));
      LS_W:    ldResult = XLEN'($signed(ldShifted[31:0]));
      LS_BU:   ldResult = XLEN'(ldShifted[7:0]);
      LS_HU:   ldResult = XLEN'(ldShifted[15:0]);
      LS_WU:   ldResult = XLEN'(ldShifted[31:0]);
      default: ldResult = ldShifted;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit between the M stage and data memory with grant/response handshake.
// Latency: store >=1 cycle of stall; load >=2 cycles, result in the DONE cycle.
// Backpressure: holds stall high until memory grants (and returns data for loads) or the timeout fires.
module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  input  logic                req_we,
  input  logic [2:0]          req_funct3,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                stall,
  output logic                resp_valid,
  output logic [XLEN-1:0]     resp_rdata,
  output logic                fault,
  output logic [1:0]          fault_cause,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN/8-1:0]   mem_be,
  output logic [XLEN-1:0]     mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [XLEN-1:0]     mem_rdata
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  lsu_state_t        state;
  lsu_state_t        stateNext;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   rdataReg;
  logic              doneLoad;
  logic              doneTimeout;

  logic              illegalSize;
  logic              misaligned;
  logic              timeoutHit;
  logic              reqIssue;
  logic              stallInt;
  logic              respValidInt;
  logic              faultInt;
  logic [1:0]        causeInt;
  logic              capture;
  logic              toTimeout;

  logic [NB-1:0]     laneBe;
  logic [XLEN-1:0]   laneWdata;
  logic [XLEN-1:0]   laneRdata;

  lsu_lane_align #(
    .XLEN (XLEN)
  ) uAlign (
    .funct3   (req_funct3),
    .off      (req_addr[OFF_W-1:0]),
    .stData   (req_wdata),
    .ldData   (mem_rdata),
    .byteEn   (laneBe),
    .stLanes  (laneWdata),
    .ldResult (laneRdata)
  );

  // Decode the requested access; an illegal size outranks misalignment
  always_comb begin
    illegalSize = (req_funct3 == 3'b111)
                || (req_we && req_funct3[2])
                || ((XLEN == 32) && ((req_funct3 == LS_D) || (req_funct3 == LS_WU)));
    misaligned  = isMisaligned(req_funct3, req_addr[2:0]);
  end

  assign timeoutHit = (TIMEOUT > 0) && (cnt == CNT_LAST);

  // Next-state and per-state control outputs
  always_comb begin
    stateNext    = state;
    reqIssue     = 1'b0;
    stallInt     = 1'b0;
    respValidInt = 1'b0;
    faultInt     = 1'b0;
    causeInt     = FC_NONE;
    capture      = 1'b0;
    toTimeout    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (illegalSize || misaligned) begin
            faultInt = 1'b1;
            causeInt = illegalSize ? FC_ILLEGAL : FC_MISALIGNED;
          end else begin
            reqIssue = 1'b1;
            stallInt = 1'b1;
            if (mem_gnt) begin
              stateNext = req_we ? DONE : WAIT;
            end else begin
              stateNext = REQ;
            end
          end
        end
      end
      REQ: begin
        reqIssue = 1'b1;
        stallInt = 1'b1;
        if (mem_gnt) begin
          stateNext = req_we ? DONE : WAIT;
        end else if (timeoutHit) begin
          stateNext = DONE;
          toTimeout = 1'b1;
        end
      end
      WAIT: begin
        stallInt = 1'b1;
        if (mem_rvalid) begin
          capture   = 1'b1;
          stateNext = DONE;
        end else if (timeoutHit) begin
          stateNext = DONE;
          toTimeout = 1'b1;
        end
      end
      DONE: begin
        respValidInt = doneLoad && !doneTimeout;
        faultInt     = doneTimeout;
        causeInt     = doneTimeout ? FC_TIMEOUT : FC_NONE;
        stateNext    = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Cycle counter for the REQ+WAIT span; held at zero while idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (state == IDLE) begin
      cnt <= '0;
    end else if ((state == REQ) || (state == WAIT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Extended load data, captured when memory returns it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdataReg <= '0;
    end else if (capture) begin
      rdataReg <= laneRdata;
    end
  end

  // Remember what kind of completion the DONE cycle must report
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      doneLoad    <= 1'b0;
      doneTimeout <= 1'b0;
    end else if ((stateNext == DONE) && (state != DONE)) begin
      doneLoad    <= !req_we;
      doneTimeout <= toTimeout;
    end
  end

  // Memory-side outputs are zero unless a request is actually being presented,
  // and every combinational output is forced low while reset is held.
  assign mem_req     = reqIssue & reset;
  assign mem_we      = mem_req & req_we;
  assign mem_addr    = mem_req ? {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign mem_be      = mem_req ? laneBe : '0;
  assign mem_wdata   = mem_we ? laneWdata : '0;
  assign stall       = stallInt & reset;
  assign resp_valid  = respValidInt & reset;
  assign fault       = faultInt & reset;
  assign fault_cause = fault ? causeInt : FC_NONE;
  assign resp_rdata  = rdataReg;

endmodule

// File: tb/tb_riscv_lsu.sv
module tb_riscv_lsu;

  localparam int XLEN    = 32;
  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              stall;
  logic              resp_valid;
  logic [XLEN-1:0]   resp_rdata;
  logic              fault;
  logic [1:0]        fault_cause;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN/8-1:0] mem_be;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;

  riscv_lsu #(
    .XLEN    (XLEN),
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .stall       (stall),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .fault       (fault),
    .fault_cause (fault_cause),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_be      (mem_be),
    .mem_wdata   (mem_wdata),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            isFault;
    logic [1:0]      cause;
    logic [XLEN-1:0] rdata;
  } exp_t;

  exp_t expQ[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic expectData(input logic [XLEN-1:0] d);
    exp_t e;
    e.isFault = 1'b0;
    e.cause   = 2'b00;
    e.rdata   = d;
    expQ.push_back(e);
  endtask

  task automatic expectFault(input logic [1:0] c);
    exp_t e;
    e.isFault = 1'b1;
    e.cause   = c;
    e.rdata   = '0;
    expQ.push_back(e);
  endtask

  // Response monitor: every resp_valid or fault pulse is matched against the scoreboard
  always @(negedge clk) begin
    if (reset === 1'b1 && (resp_valid === 1'b1 || fault === 1'b1)) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL mon_unexpected actual=rv%0b/f%0b required=no_response", resp_valid, fault);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        chk("mon_kind", {resp_valid, fault}, e.isFault ? 2'b01 : 2'b10);
        if (e.isFault) chk("mon_cause", fault_cause, e.cause);
        else           chk("mon_rdata", resp_rdata, e.rdata);
      end
    end
  end

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  task automatic atSample;
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    req_valid  = v;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
  endtask

  task automatic checkAllZero(input string tag);
    chk({tag, "_ctrl"}, {stall, resp_valid, fault, fault_cause, mem_req, mem_we, mem_be}, 0);
    chk({tag, "_maddr"}, mem_addr, 0);
    chk({tag, "_mwdata"}, mem_wdata, 0);
    chk({tag, "_rdata"}, resp_rdata, 0);
  endtask

  // Load with immediate grant and data one cycle later
  task automatic doLoad(input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] rd, input logic [31:0] expv);
    logic [31:0] aligned;
    aligned = {a[31:2], 2'b00};
    nextCycle;
    drive(1'b1, 1'b0, f3, a, 32'h0);
    mem_gnt = 1'b1;
    atSample;
    chk("ld_t_stall", stall, 1);
    chk("ld_t_req", mem_req, 1);
    chk("ld_t_addr", mem_addr, aligned);
    nextCycle;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = rd;
    expectData(expv);
    atSample;
    chk("ld_t1_stall", stall, 1);
    chk("ld_t1_req", mem_req, 0);
    chk("ld_t1_rv", resp_valid, 0);
    nextCycle;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    atSample;
    chk("ld_t2_stall", stall, 0);
    chk("ld_t2_rv", resp_valid, 1);
    nextCycle;
    req_valid = 1'b0;
    atSample;
    chk("ld_t3_rv", resp_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b0;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;

    atSample;
    checkAllZero("reset");
    nextCycle;
    reset = 1'b1;
    atSample;
    chk("idle_stall", stall, 0);

    // sb 0x103 with immediate grant
    nextCycle;
    drive(1'b1, 1'b1, 3'b000, 32'h0000_0103, 32'h0000_00AB);
    mem_gnt = 1'b1;
    atSample;
    chk("sb_req", mem_req, 1);
    chk("sb_we", mem_we, 1);
    chk("sb_addr", mem_addr, 32'h0000_0100);
    chk("sb_be", mem_be, 4'b1000);
    chk("sb_wdata", mem_wdata, 32'hABAB_ABAB);
    chk("sb_stall0", stall, 1);
    nextCycle;
    mem_gnt = 1'b0;
    atSample;
    chk("sb_stall1", stall, 0);
    chk("sb_done_req", mem_req, 0);
    nextCycle;
    req_valid = 1'b0;

    // halfword loads, signed then unsigned, and a signed byte load
    doLoad(3'b001, 32'h0000_0202, 32'h8001_1234, 32'hFFFF_8001);
    doLoad(3'b101, 32'h0000_0202, 32'h8001_1234, 32'h0000_8001);
    doLoad(3'b000, 32'h0000_0603, 32'h80FF_FFFF, 32'hFFFF_FF80);

    // lbu with grant held off one cycle; rvalid in IDLE and REQ must be ignored
    nextCycle;
    drive(1'b1, 1'b0, 3'b100, 32'h0000_0601, 32'h0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1111_1111;
    atSample;
    chk("lbu_req0", mem_req, 1);
    nextCycle;
    mem_gnt = 1'b1;
    atSample;
    chk("lbu_req1", mem_req, 1);
    chk("lbu_addr1", mem_addr, 32'h0000_0600);
    nextCycle;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    atSample;
    chk("lbu_wait_req", mem_req, 0);
    chk("lbu_wait_stall", stall, 1);
    nextCycle;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_FF00;
    expectData(32'h0000_00FF);
    atSample;
    chk("lbu_rv_early", resp_valid, 0);
    nextCycle;
    mem_rvalid = 1'b0;
    atSample;
    chk("lbu_done_rv", resp_valid, 1);
    nextCycle;
    req_valid = 1'b0;

    // lw misaligned: combinational fault, nothing issued
    nextCycle;
    drive(1'b1, 1'b0, 3'b010, 32'h0000_0301, 32'h0);
    expectFault(2'b01);
    atSample;
    chk("lw_mis_fault", fault, 1);
    chk("lw_mis_cause", fault_cause, 2'b01);
    chk("lw_mis_req", mem_req, 0);
    chk("lw_mis_stall", stall, 0);
    chk("lw_mis_rv", resp_valid, 0);

    // ld on a 32-bit core, also misaligned: illegal size wins
    nextCycle;
    drive(1'b1, 1'b0, 3'b011, 32'h0000_0401, 32'h0);
    expectFault(2'b10);
    atSample;
    chk("ld32_cause", fault_cause, 2'b10);
    chk("ld32_req", mem_req, 0);

    // store with funct3[2]=1 is illegal
    nextCycle;
    drive(1'b1, 1'b1, 3'b100, 32'h0000_0400, 32'h0);
    expectFault(2'b10);
    atSample;
    chk("sbu_cause", fault_cause, 2'b10);

    // funct3 111 is illegal
    nextCycle;
    drive(1'b1, 1'b0, 3'b111, 32'h0000_0400, 32'h0);
    expectFault(2'b10);
    atSample;
    chk("f111_cause", fault_cause, 2'b10);
    nextCycle;
    req_valid = 1'b0;

    // sw with grant withheld for 3 cycles
    nextCycle;
    drive(1'b1, 1'b1, 3'b010, 32'h0000_0500, 32'h1234_5678);
    for (int i = 0; i < 4; i++) begin
      mem_gnt = (i == 3);
      atSample;
      chk("sw_req", mem_req, 1);
      chk("sw_addr", mem_addr, 32'h0000_0500);
      chk("sw_be", mem_be, 4'b1111);
      chk("sw_wdata", mem_wdata, 32'h1234_5678);
      chk("sw_stall", stall, 1);
      nextCycle;
    end
    mem_gnt = 1'b0;
    atSample;
    chk("sw_stall_end", stall, 0);
    nextCycle;
    req_valid = 1'b0;

    // sh at upper half
    nextCycle;
    drive(1'b1, 1'b1, 3'b001, 32'h0000_0702, 32'hCAFE_BEEF);
    mem_gnt = 1'b1;
    atSample;
    chk("sh_be", mem_be, 4'b1100);
    chk("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
    nextCycle;
    mem_gnt   = 1'b0;
    nextCycle;
    req_valid = 1'b0;

    // load granted but data never returns: timeout after 8 WAIT cycles
    nextCycle;
    drive(1'b1, 1'b0, 3'b010, 32'h0000_0800, 32'h0);
    mem_gnt = 1'b1;
    atSample;
    chk("to_t_stall", stall, 1);
    nextCycle;
    mem_gnt = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      atSample;
      chk("to_wait_stall", stall, 1);
      chk("to_wait_fault", fault, 0);
      nextCycle;
    end
    expectFault(2'b11);
    atSample;
    chk("to_done_stall", stall, 0);
    chk("to_done_fault", fault, 1);
    chk("to_done_cause", fault_cause, 2'b11);
    chk("to_done_rv", resp_valid, 0);
    nextCycle;
    req_valid = 1'b0;

    // reset asserted while a load is waiting; stale rvalid after release
    nextCycle;
    drive(1'b1, 1'b0, 3'b010, 32'h0000_0900, 32'h0);
    mem_gnt = 1'b1;
    atSample;
    chk("rst_t_req", mem_req, 1);
    nextCycle;
    mem_gnt = 1'b0;
    reset   = 1'b0;
    atSample;
    checkAllZero("rst_low0");
    nextCycle;
    atSample;
    checkAllZero("rst_low1");
    nextCycle;
    reset     = 1'b1;
    req_valid = 1'b0;
    atSample;
    checkAllZero("rst_rel0");
    nextCycle;
    atSample;
    checkAllZero("rst_rel1");
    nextCycle;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    atSample;
    checkAllZero("rst_stale0");
    nextCycle;
    mem_rvalid = 1'b0;
    atSample;
    checkAllZero("rst_stale1");
    nextCycle;
    atSample;
    checkAllZero("rst_stale2");

    nextCycle;
    atSample;
    chk("sb_empty", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_lsu.md
# riscv_lsu

Parametrised load/store unit for the pipelined RISC-V core. It sits between the Memory stage and external data memory. It replaces the fixed single-cycle, word-only data port with a variable-latency grant/response handshake, and adds byte/half/word/double access, byte-lane alignment, load sign/zero extension, misalignment and illegal-size detection, and a response timeout. It drives a pipeline-wide stall while an access is outstanding.

## Interface
- XLEN, 32: data width, 32 or 64.
- ADDR_W, 32: byte-address width.
- TIMEOUT, 255: maximum cycles in REQ+WAIT before abort. 0 disables the timeout.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low; low forces reset immediately
- req_valid  in  1  M-stage instruction is a load or store
- req_we  in  1  1 = store
- req_funct3  in  3  RISC-V load/store funct3
- req_addr  in  ADDR_W  byte address (ALUResultM)
- req_wdata  in  XLEN  store data (WriteDataM)
- stall  out  1  hold F/D/E/M stages
- resp_valid  out  1  one-cycle pulse: resp_rdata valid (loads only)
- resp_rdata  out  XLEN  extended load result
- fault  out  1  one-cycle fault pulse
- fault_cause  out  2  01 misaligned, 10 illegal size, 11 timeout
- mem_req  out  1  request to memory
- mem_we  out  1  write
- mem_addr  out  ADDR_W  req_addr with low log2(XLEN/8) bits zeroed
- mem_be  out  XLEN/8  byte enables
- mem_wdata  out  XLEN  lane-replicated store data
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  load data valid; never earlier than the cycle after mem_gnt
- mem_rdata  in  XLEN  load data

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE, req_valid=1, access legal:
  - mem_req=1, stall=1.
  - With mem_gnt: store goes to DONE, load goes to WAIT.
  - Without mem_gnt: go to REQ.
- IDLE, req_valid=1, access illegal:
  - No mem_req. stall=0. fault=1 for this cycle. Stay in IDLE.
  - Misaligned: H with addr[0]≠0; W with addr[1:0]≠0; D with addr[2:0]≠0.
  - Illegal size: funct3 111; funct3 011 or 110 when XLEN=32; store with funct3[2]=1.
  - If both conditions apply, illegal size wins.
- REQ: mem_req=1, stall=1. mem_* outputs are driven from req_*, which stall keeps stable. On mem_gnt: store goes to DONE, load goes to WAIT.
- WAIT: mem_req=0, stall=1. On mem_rvalid, capture the extended data into a register and go to DONE.
- DONE: stall=0. resp_valid=1 for a load without fault. Go to IDLE.
- Timeout (TIMEOUT>0):
  - The counter clears on leaving IDLE and increments each cycle in REQ or WAIT.
  - On the TIMEOUT-th such cycle with no gnt (REQ) or rvalid (WAIT), go to DONE.
  - In that DONE cycle: fault=1, fault_cause=11, resp_valid=0.
- Stores:
  - off = addr[log2(XLEN/8)-1:0].
  - mem_be = size mask (B 1, H 3, W 0xF, D 0xFF) << off.
  - mem_wdata = low byte, half or word of req_wdata replicated across XLEN.
- Loads:
  - Shift mem_rdata right by off×8, then truncate to the access size.
  - funct3[2]=0: sign-extend. funct3[2]=1: zero-extend.
- mem_rvalid in IDLE or REQ is ignored.
- Reset low: state IDLE and counter 0. All outputs 0, including resp_rdata (its capture register resets to 0). No stale response is delivered after reset.

## Timing
- Minimum stall for a store: 1 cycle (gnt in IDLE cycle t; DONE at t+1).
- Minimum load latency: gnt at t, rvalid at t+1, resp_valid at t+2. Stall is high for t..t+1.
- mem_req, mem_addr, mem_be and mem_wdata are combinational from req_* and state.
- resp_rdata is registered and valid only in the DONE cycle.
- A misaligned or illegal-size fault is combinational in the IDLE cycle. A timeout fault appears in the DONE cycle.

## Structure
- The riscv_lsu_pkg package holds:
  - lsu_state_t enum
  - funct3 constants LS_B, LS_H, LS_W, LS_D, LS_BU, LS_HU, LS_WU
  - fault-cause constants
- Sub-module lsu_lane_align: combinational be/wdata generation and load shift/extend, parametrised on XLEN.

## Test plan
- XLEN=32, sb addr 0x103, wdata 0x000000AB, immediate gnt -> mem_addr 0x100, mem_be 1000, mem_wdata 0xABABABAB, stall high exactly 1 cycle.
- lh addr 0x202, gnt at t, rvalid t+1, mem_rdata 0x80011234 -> resp_valid at t+2, resp_rdata 0xFFFF8001. The same access as lhu -> 0x00008001.
- lw addr 0x301 -> fault=1, cause 01, mem_req 0, stall 0, resp_valid 0.
- sw with gnt withheld 3 cycles -> mem_req and mem_addr stable for 4 cycles, stall high 4 cycles, low in the 5th.
- TIMEOUT=8, load gnt at t, no rvalid -> DONE at t+9, fault cause 11, resp_valid 0, stall low at t+9.
- reset low during WAIT, stale rvalid 2 cycles after reset release -> all outputs 0 throughout, no resp_valid.
